rld: RTL and testbench

- Run-length decoder; the inverse of the team's RLE encoder.
- Reads a compressed frame from the shared dpsram over port A and expands it into the plaintext byte stream.
- Writes the plaintext back to the same dpsram over port A, packed 4 bytes per 32-bit word.
- Sits beside the encoder on the same single-port interface; the testbench or top-level controller sequences the two blocks.

---
 rtl/rld_pkg.sv | 22 ++
 rtl/rld_pack.sv | 34 +++
 rtl/rld.sv | 180 ++++++++++++++++++
 tb/tb_rld.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rld_pkg.sv
// Shared types and constants for the run-length decoder.
// Entry layout: [15:8] byte value, [7:0] run count; two entries per 32-bit word.
package rld_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    EXPAND,
    WR,
    FLUSH,
    FIN
  } state_t;

  localparam int ENTRY_W    = 16;
  localparam int WORD_BYTES = 4;
  localparam int BYTE_HI    = 15;
  localparam int BYTE_LO    = 8;
  localparam int CNT_HI     = 7;
  localparam int CNT_LO     = 0;

endpackage

// File: rtl/rld_pack.sv
// Byte-to-word packer: collects up to four bytes little-endian into one 32-bit word.
// Unfilled upper lanes stay zero because clear zeroes the whole word.
module rld_pack (
  input  logic        clk,
  input  logic        nreset,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [1:0]  lane,
  output logic        full,
  output logic        nonempty,
  output logic [31:0] data
);

  logic [2:0] count;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count <= 3'd0;
      data  <= 32'd0;
    end else if (clear) begin
      count <= 3'd0;
      data  <= 32'd0;
    end else if (push && !full) begin
      data[lane*8 +: 8] <= byte_in;
      count             <= count + 3'd1;
    end
  end

  assign lane     = count[1:0];
  assign full     = count[2];
  assign nonempty = |count;

endmodule

// File: rtl/rld.sv
// Run-length decoder: reads a compressed frame over port A and writes the packed plaintext back.
// Optional length limit (max_len input, overflow output) is enabled by defining RLD_MAX_LEN_EN.
module rld
  import rld_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int COUNT_W = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [31:0]       rle_addr,
  input  logic [31:0]       rle_size,
  input  logic [31:0]       message_addr,
  output logic [31:0]       message_size,
  output logic              done,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out
`ifdef RLD_MAX_LEN_EN
  ,
  input  logic [31:0]       max_len,
  output logic              overflow
`endif
);

  state_t             state, state_next, resume, after_entry;
  logic [ADDR_W-1:0]  rd_ptr, wr_ptr;
  logic [29:0]        budget;
  logic [31:0]        entry;
  logic               sel_hi;
  logic [COUNT_W-1:0] cnt, hi_cnt;
  logic [7:0]         cur_byte;
  logic               has_byte, over, push, pack_clear;
  logic [1:0]         lane;
  logic               pack_full, pack_nonempty;
  logic [31:0]        pack_data;
  logic               unused_bits;

  assign port_A_clk  = clk;
  assign cur_byte    = sel_hi ? entry[ENTRY_W+BYTE_HI:ENTRY_W+BYTE_LO] : entry[BYTE_HI:BYTE_LO];
  assign hi_cnt      = entry[ENTRY_W+CNT_HI:ENTRY_W+CNT_LO];
  assign has_byte    = (cnt != '0);
  assign push        = (state == EXPAND) && has_byte && !over;
  assign unused_bits = ^{rle_addr[31:ADDR_W], message_addr[31:ADDR_W], rle_size[1:0], pack_full};

`ifdef RLD_MAX_LEN_EN
  logic [31:0] max_len_reg;
  // The next byte would make message_size exceed the limit.
  assign over = has_byte && (message_size >= max_len_reg);
`else
  assign over = 1'b0;
`endif

  // Where expansion continues once the current byte (if any) is consumed.
  always_comb begin
    after_entry = EXPAND;
    if (cnt <= COUNT_W'(1) && sel_hi)
      after_entry = (budget != '0) ? RD_REQ : FLUSH;
  end

  rld_pack u_pack (
    .clk      (clk),
    .nreset   (nreset),
    .clear    (pack_clear),
    .push     (push),
    .byte_in  (cur_byte),
    .lane     (lane),
    .full     (pack_full),
    .nonempty (pack_nonempty),
    .data     (pack_data)
  );

  always_comb begin
    state_next     = state;
    port_A_we      = 1'b0;
    port_A_addr    = '0;
    port_A_data_in = 32'd0;
    pack_clear     = 1'b0;
    case (state)
      IDLE:    if (start) state_next = (rle_size[31:2] == 30'd0) ? FIN : RD_REQ;
      RD_REQ: begin
        port_A_addr = rd_ptr;
        state_next  = RD_WAIT;
      end
      RD_WAIT: state_next = EXPAND;
      EXPAND: begin
        if (over)
          state_next = FLUSH;
        else if (push && lane == 2'd3)
          state_next = WR;
        else
          state_next = after_entry;
      end
      WR: begin
        port_A_we      = 1'b1;
        port_A_addr    = wr_ptr;
        port_A_data_in = pack_data;
        pack_clear     = 1'b1;
        // Packer is empty after this write, so a pending flush collapses to FIN.
        state_next     = (resume == FLUSH) ? FIN : resume;
      end
      FLUSH: begin
        if (pack_nonempty) begin
          port_A_we      = 1'b1;
          port_A_addr    = wr_ptr;
          port_A_data_in = pack_data;
          pack_clear     = 1'b1;
        end
        state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      resume       <= IDLE;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      budget       <= '0;
      entry        <= 32'd0;
      sel_hi       <= 1'b0;
      cnt          <= '0;
      message_size <= 32'd0;
      done         <= 1'b0;
`ifdef RLD_MAX_LEN_EN
      max_len_reg  <= 32'd0;
      overflow     <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          rd_ptr       <= rle_addr[ADDR_W-1:0];
          wr_ptr       <= message_addr[ADDR_W-1:0];
          budget       <= rle_size[31:2];
          message_size <= 32'd0;
          done         <= 1'b0;
`ifdef RLD_MAX_LEN_EN
          max_len_reg  <= max_len;
          overflow     <= 1'b0;
`endif
        end
        RD_WAIT: begin
          entry  <= port_A_data_out;
          cnt    <= port_A_data_out[CNT_HI:CNT_LO];
          sel_hi <= 1'b0;
          rd_ptr <= rd_ptr + ADDR_W'(WORD_BYTES);
          budget <= budget - 30'd1;
        end
        EXPAND: begin
          if (over) begin
`ifdef RLD_MAX_LEN_EN
            overflow <= 1'b1;
`endif
          end else begin
            if (push) message_size <= message_size + 32'd1;
            if (cnt <= COUNT_W'(1) && !sel_hi) begin
              sel_hi <= 1'b1;
              cnt    <= hi_cnt;
            end else if (has_byte) begin
              cnt <= cnt - COUNT_W'(1);
            end
            resume <= after_entry;
          end
        end
        WR:      wr_ptr <= wr_ptr + ADDR_W'(WORD_BYTES);
        FLUSH:   if (pack_nonempty) wr_ptr <= wr_ptr + ADDR_W'(WORD_BYTES);
        FIN:     done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rld.sv
// Self-checking bench for rld: byte-list reference model, dpsram model and write scoreboard.
// Define RLD_MAX_LEN_EN to also exercise the length-limit feature.
module tb_rld;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] rle_addr = 32'd0, rle_size = 32'd0, message_addr = 32'd0;
  logic [31:0] message_size;
  logic        done;
  logic        port_A_clk;
  logic [15:0] port_A_addr;
  logic        port_A_we;
  logic [31:0] port_A_data_in;
  logic [31:0] port_A_data_out;
`ifdef RLD_MAX_LEN_EN
  logic [31:0] max_len = 32'hFFFF_FFFF;
  logic        overflow;
`endif

  rld dut (
    .clk             (clk),
    .nreset          (nreset),
    .start           (start),
    .rle_addr        (rle_addr),
    .rle_size        (rle_size),
    .message_addr    (message_addr),
    .message_size    (message_size),
    .done            (done),
    .port_A_clk      (port_A_clk),
    .port_A_addr     (port_A_addr),
    .port_A_we       (port_A_we),
    .port_A_data_in  (port_A_data_in),
    .port_A_data_out (port_A_data_out)
`ifdef RLD_MAX_LEN_EN
    ,
    .max_len         (max_len),
    .overflow        (overflow)
`endif
  );

  always #5 clk = ~clk;

  // dpsram model: one-cycle registered read; bench loads frames through its own port.
  logic [31:0] mem [0:16383];
  logic        load_en = 1'b0;
  logic [13:0] load_idx = 14'd0;
  logic [31:0] load_word = 32'd0;

  always @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_word;
    else if (port_A_we) mem[port_A_addr[15:2]] <= port_A_data_in;
    port_A_data_out <= mem[port_A_addr[15:2]];
  end

  int          vectors = 0, miscompares = 0, writes = 0;
  logic [15:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] frame[16];
  int          exp_size;
  bit          exp_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Scoreboard: every write cycle must match the next expected word and address.
  always @(negedge clk) begin
    if (nreset && port_A_we) begin
      writes++;
      if (exp_addr.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr 0x%04h data 0x%08h, expected no write",
                 port_A_addr, port_A_data_in);
      end else begin
        check("wr_addr", {16'd0, port_A_addr}, {16'd0, exp_addr.pop_front()});
        check("wr_data", port_A_data_in, exp_data.pop_front());
      end
    end
  end

  // Reference: expand entries into a byte list, truncate at the limit, pack by fours.
  task automatic build_model(input int nwords, input logic [31:0] maddr, input logic [31:0] maxlen);
    logic [7:0]  q[$];
    logic [15:0] ent;
    logic [31:0] wd;
    for (int w = 0; w < nwords; w++)
      for (int e = 0; e < 2; e++) begin
        ent = frame[w][16*e +: 16];
        for (int c = 0; c < int'(ent[7:0]); c++) q.push_back(ent[15:8]);
      end
    exp_ovf = longint'(q.size()) > longint'(maxlen);
    while (longint'(q.size()) > longint'(maxlen)) q.pop_back();
    exp_size = q.size();
    for (int i = 0; i < q.size(); i += 4) begin
      wd = 32'd0;
      for (int b = 0; b < 4; b++)
        if (i + b < q.size()) wd[8*b +: 8] = q[i+b];
      exp_addr.push_back(16'(maddr + 32'(i)));
      exp_data.push_back(wd);
    end
  endtask

  task automatic load_frame(input logic [31:0] raddr, input int nwords);
    for (int i = 0; i < nwords; i++) begin
      @(negedge clk);
      load_en   = 1'b1;
      load_idx  = 14'(raddr[15:2] + 14'(i));
      load_word = frame[i];
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic run(input string name, input logic [31:0] raddr, input int nwords,
                     input logic [31:0] maddr, input logic [31:0] maxlen, input bit poke,
                     output int cycles);
    load_frame(raddr, nwords);
    build_model(nwords, maddr, maxlen);
    writes = 0;
    @(negedge clk);
    rle_addr     = raddr;
    rle_size     = 32'(nwords * 4);
    message_addr = maddr;
`ifdef RLD_MAX_LEN_EN
    max_len      = maxlen;
`endif
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    check({name, "_done_cleared"}, {31'd0, done}, 32'd0);
    while (!done && cycles < 20000) begin
      // A start while busy must be ignored.
      if (poke && cycles == 4) begin
        start    = 1'b1;
        rle_addr = 32'h0000_0100;
        rle_size = 32'h40;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_message_size"}, message_size, 32'(exp_size));
    check({name, "_missing_writes"}, 32'(exp_addr.size()), 32'd0);
`ifdef RLD_MAX_LEN_EN
    check({name, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
`endif
    exp_addr.delete();
    exp_data.delete();
    $display("decode %s: words=%0d bytes=%0d writes=%0d cycles=%0d", name, nwords, message_size,
             writes, cycles);
  endtask

  int          cyc, nw, guard;
  logic [31:0] ra, ma, ml;
  logic [7:0]  cnt_a, cnt_b;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_message_size", message_size, 32'd0);
    check("rst_we", {31'd0, port_A_we}, 32'd0);
    check("rst_addr", {16'd0, port_A_addr}, 32'd0);
    check("rst_data_in", port_A_data_in, 32'd0);
    nreset = 1'b1;

    frame[0] = 32'h0203_4105;
    run("basic", 32'h1000, 1, 32'h2000, 32'hFFFF_FFFF, 1'b0, cyc);
    check("basic_mem0", mem[14'h800], 32'h4141_4141);
    check("basic_mem1", mem[14'h801], 32'h0202_0241);
    check("basic_size_lit", message_size, 32'd8);

    run("empty", 32'h1000, 0, 32'h3000, 32'hFFFF_FFFF, 1'b0, cyc);
    check("empty_latency", 32'(cyc), 32'd2);
    check("empty_writes", 32'(writes), 32'd0);

    frame[0] = 32'h0000_4103;
    run("pad_hi", 32'h1000, 1, 32'h3000, 32'hFFFF_FFFF, 1'b0, cyc);
    check("pad_hi_mem", mem[14'hC00], 32'h0041_4141);
    check("pad_hi_writes", 32'(writes), 32'd1);

    frame[0] = 32'h0000_FFFF;
    run("wrap", 32'h4000, 1, 32'h0000_FFF0, 32'hFFFF_FFFF, 1'b0, cyc);
    check("wrap_writes", 32'(writes), 32'd64);
    check("wrap_first", mem[14'h3FFC], 32'hFFFF_FFFF);
    check("wrap_last", mem[14'h003B], 32'h00FF_FFFF);
    check("wrap_size_lit", message_size, 32'd255);

    // Asynchronous reset in the middle of expansion.
    frame[0] = 32'h0203_4105;
    load_frame(32'h1000, 1);
    @(negedge clk);
    rle_addr = 32'h1000; rle_size = 32'd4; message_addr = 32'h5000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (message_size != 32'd2 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reached_expand", message_size, 32'd2);
    #2 nreset = 1'b0;
    #1;
    check("abort_we", {31'd0, port_A_we}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_message_size", message_size, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    run("after_abort", 32'h1000, 1, 32'h6000, 32'hFFFF_FFFF, 1'b0, cyc);
    check("after_abort_mem0", mem[14'h1800], 32'h4141_4141);
    check("after_abort_mem1", mem[14'h1801], 32'h0202_0241);

    run("start_ignored", 32'h1000, 1, 32'h7000, 32'hFFFF_FFFF, 1'b1, cyc);
    check("start_ignored_mem1", mem[14'h1C01], 32'h0202_0241);

`ifdef RLD_MAX_LEN_EN
    run("max_len5", 32'h1000, 1, 32'h7100, 32'd5, 1'b0, cyc);
    check("max_len5_ovf_lit", {31'd0, overflow}, 32'd1);
    check("max_len5_mem0", mem[14'h1C40], 32'h4141_4141);
    check("max_len5_mem1", mem[14'h1C41], 32'h0000_0041);
`endif

    for (int t = 0; t < 25; t++) begin
      nw = $urandom_range(1, 6);
      for (int w = 0; w < nw; w++) begin
        cnt_a = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
        cnt_b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 9));
        frame[w] = {8'($urandom), cnt_b, 8'($urandom), cnt_a};
      end
      ra = {16'($urandom), 16'h1000 + 16'($urandom_range(0, 255) * 4)};
      ma = {16'($urandom), 16'h8000 + 16'($urandom_range(0, 255) * 4)};
      ml = 32'hFFFF_FFFF;
`ifdef RLD_MAX_LEN_EN
      if ($urandom_range(0, 1) == 1) ml = 32'($urandom_range(0, 60));
`endif
      run($sformatf("rand%0d", t), ra, nw, ma, ml, 1'($urandom_range(0, 1)), cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
